// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port and a data load/store port. Data has fixed priority over fetch.
// Each transaction runs IDLE -> ISSUE -> WAIT* -> RESP -> IDLE.
// Optional: define MEM_ARB_TIMEOUT_EN to bound WAIT at 15 cycles; on expiry
// the sticky err flag is set and the owner completes with zero read data.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0] state;
  logic       owner;    // 0 = fetch, 1 = data
  logic       timeout;  // WAIT has expired without mem_done this cycle

  // Strobes and stalls are decoded straight from state so reset clears them at once
  assign mem_en   = (state == ISSUE);
  assign if_done  = (state == RESP) && !owner;
  assign d_done   = (state == RESP) &&  owner;
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req  & ~d_done;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [3:0] tcnt;

  // The 15th consecutive WAIT cycle sees tcnt == 14 (first WAIT cycle sees 0)
  assign timeout = (state == WAIT) && (tcnt == 4'd14) && !mem_done;

  // WAIT-cycle counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (state == ISSUE)
        tcnt <= '0;
      else if (state == WAIT && !mem_done)
        tcnt <= tcnt + 4'd1;
      if (timeout)
        err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Arbitration, command latching and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            owner     <= 1'b1;
            mem_wr    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= ISSUE;
          end else if (if_req) begin
            owner    <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= if_addr;
            state    <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (mem_done) begin
            if (!owner)
              if_rdata <= mem_rdata;
            else if (!mem_wr)
              d_rdata <= mem_rdata;
            state <= RESP;
          end else if (timeout) begin
            if (!owner)
              if_rdata <= '0;
            else if (!mem_wr)
              d_rdata <= '0;
            state <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;  // RESP: done pulse lasts this one cycle
      endcase
    end
  end

endmodule
